crc_table_builder: RTL
======================

# crc_table_builder

Runtime generator for the 256-entry, 32-bit CRC lookup tables that the pipelined LUT-CRC datapath reads. The block sits on the write side of a table RAM. It computes the table for a given reflected polynomial and byte-advance stride, then streams all 256 words into the RAM through a simple write port. One instance serves one table stage, so stage tables become reprogrammable instead of being fixed ROM contents.

## Interface
Parameters:
- POLY, 32'hEDB88320 — reflected (LSB-first) CRC-32 polynomial.
- SHIFT_BYTES, 1 — number of zero bytes the table advances over; stage N of the pipeline uses N. Legal range 1..64.

Ports:
- clk  in  1  — single clock.
- rstn  in  1  — reset, synchronous, active-low.
- start  in  1  — build request; sampled only in IDLE.
- busy  out  1  — high from the cycle after an accepted start through the last write.
- done  out  1  — one-cycle pulse after the last write.
- tbl_we  out  1  — table RAM write enable.
- tbl_waddr  out  8  — table RAM write address.
- tbl_wdata  out  32  — table RAM write data.
- selftest_err  out  1  — present only with CRC_TABLE_BUILDER_SELFTEST_EN.

## Operation
- Table definition: T[i] = F(i), where F(v) shifts crc = v (zero-extended to 32 bits) 8*SHIFT_BYTES times. Each shift is crc = crc[0] ? (crc>>1)^POLY : crc>>1.
- F is linear over GF(2). The block therefore computes only the eight basis words B[k] = F(1<<k) bit-serially. Every other entry is T[i] = XOR over k of (i[k] ? B[k] : 0).
- FSM states: IDLE, BASIS, FILL, DONE.
  - IDLE: all outputs 0. start=1 → BASIS with k=0, crc=32'h1, shift counter=0.
  - BASIS: one shift per cycle. After 8*SHIFT_BYTES shifts, store B[k]. Then either load crc=1<<(k+1) and continue, or go to FILL once k=7.
  - FILL: one write per cycle. tbl_we=1, tbl_waddr=i, tbl_wdata=T[i], for i = 0..255 in ascending order. After i=255 → DONE.
  - DONE: done=1 and busy=0 for one cycle, then → IDLE.
- Storage: basis register file of 8×32 bits, a 32-bit shift register, a 3-bit k counter, a shift counter of width clog2(8*SHIFT_BYTES+1), and an 8-bit fill index.
- T[0] is always 32'h0 and is written like any other entry.
- start asserted while busy, or in DONE, is ignored; there is no queuing.
- rstn low in any state: next cycle, state=IDLE and all outputs 0. RAM contents written so far are left as they are; the consumer must rebuild.

## Timing
- Start sampled at cycle 0 → busy=1 at cycle 1.
- BASIS occupies 64*SHIFT_BYTES cycles.
- FILL occupies the following 256 cycles, one write each.
- done pulses the cycle after the i=255 write.
- Total from start to done: 1 + 64*SHIFT_BYTES + 256 cycles (SHIFT_BYTES=1 → done at cycle 321).
- Write outputs are registered; tbl_waddr and tbl_wdata are valid in the same cycle as tbl_we.
- Reset values: busy=0, done=0, tbl_we=0, tbl_waddr=0, tbl_wdata=0, selftest_err=0.

## Configuration
- CRC_TABLE_BUILDER_SELFTEST_EN defined: during FILL, at i=8'hFF, a second bit-serial engine compares its result against the XOR-composed value.
  - The second engine runs F(8'hFF) in parallel with BASIS, so it adds no cycles.
  - On mismatch, selftest_err is set. It stays set until the next accepted start or reset.
- Not defined: the second engine and the selftest_err port are absent; timing is unchanged.

## Structure
- Shared package crc_pkg holds:
  - CRC_W=32, TBL_DEPTH=256, TBL_AW=8;
  - the state enum typedef;
  - a function crc_shift(crc, poly) for one reflected shift step, reused by the datapath.
- Natural sub-module: crc_serial_shifter. It loads a seed, runs N shifts, and raises a done flag. It is instantiated once, plus a second copy under CRC_TABLE_BUILDER_SELFTEST_EN.

## Test plan
- Standard CRC-32 (POLY=EDB88320, SHIFT_BYTES=1), start pulse:
  - writes T[0]=00000000, T[1]=77073096, T[0x80]=EDB88320, T[0xFF]=2D02EF8D;
  - exactly 256 writes, addresses ascending;
  - done pulses at cycle 321.
- SHIFT_BYTES=17: the full table matches a bench bit-serial model for all 256 entries.
  - Linearity holds, e.g. T[1]^T[2]==T[3].
  - done pulses at cycle 1+1088+256=1345.
- start held high for the whole run: exactly one build; no second build begins while busy.
- rstn deasserted during FILL at i=100:
  - next cycle all outputs are 0 and the state is IDLE;
  - a new start produces a complete, correct table.
- start pulsed in the DONE cycle: ignored, no writes follow.
- With CRC_TABLE_BUILDER_SELFTEST_EN defined:
  - a correct build leaves selftest_err=0;
  - a forced corruption of B[3] sets selftest_err at the i=FF write, and a subsequent start clears it.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared definitions for the CRC table builder: widths, FSM state type and the
// single reflected (LSB-first) shift step used by every bit-serial engine.
package crc_pkg;

  localparam int unsigned CRC_W     = 32;
  localparam int unsigned TBL_DEPTH = 256;
  localparam int unsigned TBL_AW    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StBasis,
    StFill,
    StDone
  } state_e;

  // One reflected CRC step: shift right, fold in the polynomial when a one falls out.
  function automatic logic [CRC_W-1:0] crc_shift(input logic [CRC_W-1:0] crc,
                                                 input logic [CRC_W-1:0] poly);
    return crc[0] ? ((crc >> 1) ^ poly) : (crc >> 1);
  endfunction

endpackage

// File: rtl/crc_serial_shifter.sv
// Bit-serial CRC engine: loads a seed, then applies NSHIFT reflected shifts, one per cycle.
//   clk, rstn : clock, synchronous active-low reset
//   load      : load seed and (re)start; overrides any run in progress
//   seed      : value loaded on load
//   result    : shifted value that the current cycle commits
//   done      : high in the cycle whose edge commits the final shift; result is the answer
module crc_serial_shifter
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY   = 32'hEDB88320,
  parameter int unsigned      NSHIFT = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CRC_W-1:0] seed,
  output logic [CRC_W-1:0] result,
  output logic             done
);

  localparam int unsigned CntW = $clog2(NSHIFT + 1);

  logic [CRC_W-1:0] crc_q;
  logic [CntW-1:0]  cnt_q;
  logic             run_q;

  assign result = crc_shift(crc_q, POLY);
  assign done   = run_q && (cnt_q == CntW'(NSHIFT - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      crc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      crc_q <= seed;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      crc_q <= result;
      cnt_q <= done ? '0 : cnt_q + 1'b1;
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/crc_table_builder.sv
// Runtime generator for a 256 x 32 LUT-CRC table advancing SHIFT_BYTES zero bytes.
// Computes the eight basis words B[k] = F(1<<k) bit-serially, then streams
// T[i] = XOR of B[k] over the set bits of i into a table RAM, addresses 0..255.
//   clk, rstn    : clock, synchronous active-low reset
//   start        : build request, sampled only while idle
//   busy         : high from the cycle after an accepted start through the last write
//   done         : one-cycle pulse after the last write
//   tbl_we/waddr/wdata : registered RAM write port
//   selftest_err : only when CRC_TABLE_BUILDER_SELFTEST_EN is defined; a second engine
//                  computes F(8'hFF) directly and flags a mismatch with the composed T[FF]
module crc_table_builder
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY        = 32'hEDB88320,
  parameter int unsigned      SHIFT_BYTES = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              tbl_we,
  output logic [TBL_AW-1:0] tbl_waddr,
  output logic [CRC_W-1:0]  tbl_wdata
`ifdef CRC_TABLE_BUILDER_SELFTEST_EN
  ,
  output logic              selftest_err
`endif
);

  localparam int unsigned NShift  = 8 * SHIFT_BYTES;
  localparam logic [TBL_AW-1:0] LastIdx = TBL_AW'(TBL_DEPTH - 1);

  state_e            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [CRC_W-1:0]  basis_q [8];
  logic              basis_we;
  logic              start_acc;
  logic              sh_load;
  logic [CRC_W-1:0]  sh_seed;
  logic [CRC_W-1:0]  sh_result;
  logic              sh_done;
  logic [CRC_W-1:0]  fill_data;

  assign start_acc = (state_q == StIdle) && start;

  crc_serial_shifter #(
    .POLY   (POLY),
    .NSHIFT (NShift)
  ) u_shifter (
    .clk    (clk),
    .rstn   (rstn),
    .load   (sh_load),
    .seed   (sh_seed),
    .result (sh_result),
    .done   (sh_done)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    idx_d    = idx_q;
    sh_load  = 1'b0;
    sh_seed  = CRC_W'(1);
    basis_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBasis;
          k_d     = 3'd0;
          sh_load = 1'b1;
        end
      end
      StBasis: begin
        if (sh_done) begin
          basis_we = 1'b1;
          if (k_q == 3'd7) begin
            state_d = StFill;
            idx_d   = '0;
          end else begin
            // Reload in the same cycle so consecutive basis words have no gap.
            k_d     = k_q + 3'd1;
            sh_load = 1'b1;
            sh_seed = CRC_W'(1) << (k_q + 3'd1);
          end
        end
      end
      StFill: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Composed entry for the index about to be written; T[0] needs no basis word,
  // so B[7] landing on the FILL entry edge is not a hazard.
  always_comb begin
    fill_data = '0;
    for (int k = 0; k < 8; k++) begin
      if (idx_d[k]) begin
        fill_data = fill_data ^ basis_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (basis_we) begin
      basis_q[k_q] <= sh_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      k_q       <= 3'd0;
      idx_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tbl_we    <= 1'b0;
      tbl_waddr <= '0;
      tbl_wdata <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      idx_q     <= idx_d;
      busy      <= (state_d == StBasis) || (state_d == StFill);
      done      <= (state_d == StDone);
      tbl_we    <= (state_d == StFill);
      tbl_waddr <= (state_d == StFill) ? idx_d : '0;
      tbl_wdata <= (state_d == StFill) ? fill_data : '0;
    end
  end

`ifdef CRC_TABLE_BUILDER_SELFTEST_EN
  logic [CRC_W-1:0] st_result;
  logic             st_done;
  logic [CRC_W-1:0] st_ref_q;

  // Runs alongside the k=0 basis pass, so it costs no cycles.
  crc_serial_shifter #(
    .POLY   (POLY),
    .NSHIFT (NShift)
  ) u_selftest (
    .clk    (clk),
    .rstn   (rstn),
    .load   (start_acc),
    .seed   (CRC_W'(8'hFF)),
    .result (st_result),
    .done   (st_done)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_ref_q     <= '0;
      selftest_err <= 1'b0;
    end else begin
      if (st_done) begin
        st_ref_q <= st_result;
      end
      if (start_acc) begin
        selftest_err <= 1'b0;
      end else if ((state_d == StFill) && (idx_d == LastIdx) && (fill_data != st_ref_q)) begin
        selftest_err <= 1'b1;
      end
    end
  end
`else
  // No reference engine: table is produced purely from the basis words.
`endif

endmodule
